// File: rtl/stack_pkg.sv
// Shared constants and command decode for the operand stack.
package stack_pkg;

   localparam int STACK_WIDTH = 8;
   localparam int STACK_DEPTH = 16;

   typedef enum logic [2:0] {
      CMD_NONE,
      CMD_PUSH,
      CMD_POP,
      CMD_TOS,
      CMD_ILLEGAL
   } cmd_t;

   // One-hot check of the three command strobes; any overlap is illegal.
   function automatic cmd_t decode_cmd(input logic push, input logic pop, input logic tos);
      unique case ({push, pop, tos})
         3'b000:  return CMD_NONE;
         3'b100:  return CMD_PUSH;
         3'b010:  return CMD_POP;
         3'b001:  return CMD_TOS;
         default: return CMD_ILLEGAL;
      endcase
   endfunction

endpackage

// File: rtl/stack_ram.sv
// DEPTH x WIDTH register file: synchronous write, asynchronous read.
// Contents are deliberately not reset; the stack pointer defines validity.
module stack_ram
   import stack_pkg::*;
#(
   parameter int WIDTH = STACK_WIDTH,
   parameter int DEPTH = STACK_DEPTH,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port, committed at the clock edge so a following read sees it.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// Hardware operand stack: one push/pop/tos command per cycle, registered
// top-of-stack output, full/empty status and sticky error flags.
module stack_unit
   import stack_pkg::*;
#(
   parameter int WIDTH = STACK_WIDTH,
   parameter int DEPTH = STACK_DEPTH,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             tos,
   input  logic [WIDTH-1:0] din,
   input  logic             clr_err,
   output logic [WIDTH-1:0] dout,
   output logic             dout_vld,
   output logic             empty,
   output logic             full,
   output logic [CNT_W-1:0] count,
   output logic             ovf_err,
   output logic             udf_err,
   output logic             cmd_err
);

   localparam int AW = $clog2(DEPTH);

   logic [CNT_W-1:0] sp;       // next free slot; equals occupancy
   logic [WIDTH-1:0] rdata;
   cmd_t             cmd;
   logic             do_push, do_read, do_pop;
   logic             ovf_now, udf_now, ill_now;
   logic [AW-1:0]    waddr, raddr;

   assign count = sp;
   assign empty = (sp == '0);
   assign full  = (sp == CNT_W'(DEPTH));

   assign cmd     = decode_cmd(push, pop, tos);
   assign do_push = (cmd == CMD_PUSH) && !full;
   assign do_read = ((cmd == CMD_POP) || (cmd == CMD_TOS)) && !empty;
   assign do_pop  = (cmd == CMD_POP) && !empty;
   assign ovf_now = (cmd == CMD_PUSH) && full;
   assign udf_now = ((cmd == CMD_POP) || (cmd == CMD_TOS)) && empty;
   assign ill_now = (cmd == CMD_ILLEGAL);

   // Address truncation is safe: no write when full, no read when empty.
   assign waddr = sp[AW-1:0];
   assign raddr = AW'(sp - CNT_W'(1));

   stack_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
      .clk   (clk),
      .we    (do_push),
      .waddr (waddr),
      .wdata (din),
      .raddr (raddr),
      .rdata (rdata)
   );

   // Pointer, output register and sticky flags; a new error beats clr_err.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sp       <= '0;
         dout     <= '0;
         dout_vld <= 1'b0;
         ovf_err  <= 1'b0;
         udf_err  <= 1'b0;
         cmd_err  <= 1'b0;
      end else begin
         dout_vld <= do_read;
         if (do_read) dout <= rdata;
         if (do_push)     sp <= sp + CNT_W'(1);
         else if (do_pop) sp <= sp - CNT_W'(1);
         ovf_err <= ovf_now | (ovf_err & ~clr_err);
         udf_err <= udf_now | (udf_err & ~clr_err);
         cmd_err <= ill_now | (cmd_err & ~clr_err);
      end
   end

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit: one task per scenario, inline checks.
module tb_stack_unit;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;
   localparam int CNT_W = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             push, pop, tos, clr_err;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] dout;
   logic             dout_vld, empty, full, ovf_err, udf_err, cmd_err;
   logic [CNT_W-1:0] count;

   int checks = 0;
   int errors = 0;

   stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .pop      (pop),
      .tos      (tos),
      .din      (din),
      .clr_err  (clr_err),
      .dout     (dout),
      .dout_vld (dout_vld),
      .empty    (empty),
      .full     (full),
      .count    (count),
      .ovf_err  (ovf_err),
      .udf_err  (udf_err),
      .cmd_err  (cmd_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1);
   end

   // Drive one command for a single cycle; returns 1 time unit after the edge.
   task automatic do_cmd(input logic p, input logic po, input logic t,
                         input logic [WIDTH-1:0] d, input logic c);
      push = p; pop = po; tos = t; din = d; clr_err = c;
      @(posedge clk); #1;
      push = 0; pop = 0; tos = 0; din = '0; clr_err = 0;
   endtask

   task automatic apply_reset;
      push = 0; pop = 0; tos = 0; din = '0; clr_err = 0;
      rst = 1;
      @(posedge clk); #3;
      rst = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      apply_reset();
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
      checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", dout); end
      checks++; if (dout_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", dout_vld); end
      checks++; if ({ovf_err, udf_err, cmd_err} !== 3'b000) begin errors++; $display("FAIL reset_errs: got %b want 000", {ovf_err, udf_err, cmd_err}); end
   endtask

   task automatic test_push_pop;
      do_cmd(1, 0, 0, 8'h05, 0);
      checks++; if (dout_vld !== 1'b0) begin errors++; $display("FAIL push_vld: got %b want 0", dout_vld); end
      do_cmd(1, 0, 0, 8'h0A, 0);
      checks++; if (count !== 5'd2) begin errors++; $display("FAIL push_count: got %0d want 2", count); end
      do_cmd(0, 1, 0, 8'h00, 0);
      checks++; if (dout !== 8'h0A) begin errors++; $display("FAIL pop_dout: got %h want 0a", dout); end
      checks++; if (dout_vld !== 1'b1) begin errors++; $display("FAIL pop_vld: got %b want 1", dout_vld); end
      checks++; if (count !== 5'd1) begin errors++; $display("FAIL pop_count: got %0d want 1", count); end
      @(posedge clk); #1;
      checks++; if (dout_vld !== 1'b0) begin errors++; $display("FAIL vld_pulse: got %b want 0", dout_vld); end
      checks++; if (dout !== 8'h0A) begin errors++; $display("FAIL dout_hold: got %h want 0a", dout); end
   endtask

   task automatic test_tos;
      for (int i = 0; i < 2; i++) begin
         do_cmd(0, 0, 1, 8'h00, 0);
         checks++; if (dout !== 8'h05) begin errors++; $display("FAIL tos_dout%0d: got %h want 05", i, dout); end
         checks++; if (dout_vld !== 1'b1) begin errors++; $display("FAIL tos_vld%0d: got %b want 1", i, dout_vld); end
         checks++; if (count !== 5'd1) begin errors++; $display("FAIL tos_count%0d: got %0d want 1", i, count); end
      end
      do_cmd(0, 1, 0, 8'h00, 0);
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL tos_pop_count: got %0d want 0", count); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL tos_pop_empty: got %b want 1", empty); end
      checks++; if (dout !== 8'h05) begin errors++; $display("FAIL tos_pop_dout: got %h want 05", dout); end
   endtask

   task automatic test_overflow;
      apply_reset();
      for (int i = 0; i < 16; i++) do_cmd(1, 0, 0, 8'(i), 0);
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", full); end
      checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count16: got %0d want 16", count); end
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b want 0", empty); end
      do_cmd(1, 0, 0, 8'hFF, 0);
      checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", ovf_err); end
      checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count_held: got %0d want 16", count); end
      // Error and clear in the same cycle: error wins.
      do_cmd(1, 0, 0, 8'hFF, 1);
      checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_err_wins: got %b want 1", ovf_err); end
      do_cmd(0, 1, 0, 8'h00, 0);
      checks++; if (dout !== 8'h0F) begin errors++; $display("FAIL ovf_pop_dout: got %h want 0f", dout); end
      checks++; if (count !== 5'd15) begin errors++; $display("FAIL ovf_pop_count: got %0d want 15", count); end
      checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", ovf_err); end
      do_cmd(0, 0, 0, 8'h00, 1);
      checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", ovf_err); end
   endtask

   task automatic test_underflow;
      apply_reset();
      do_cmd(1, 0, 0, 8'h77, 0);
      do_cmd(0, 1, 0, 8'h00, 0);
      checks++; if (dout !== 8'h77) begin errors++; $display("FAIL udf_setup_dout: got %h want 77", dout); end
      do_cmd(0, 1, 0, 8'h00, 0);
      checks++; if (udf_err !== 1'b1) begin errors++; $display("FAIL udf_pop_flag: got %b want 1", udf_err); end
      checks++; if (dout_vld !== 1'b0) begin errors++; $display("FAIL udf_pop_vld: got %b want 0", dout_vld); end
      checks++; if (dout !== 8'h77) begin errors++; $display("FAIL udf_pop_dout: got %h want 77", dout); end
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL udf_count: got %0d want 0", count); end
      do_cmd(0, 0, 1, 8'h00, 0);
      checks++; if (dout_vld !== 1'b0) begin errors++; $display("FAIL udf_tos_vld: got %b want 0", dout_vld); end
      checks++; if (dout !== 8'h77) begin errors++; $display("FAIL udf_tos_dout: got %h want 77", dout); end
      do_cmd(0, 0, 0, 8'h00, 1);
      checks++; if (udf_err !== 1'b0) begin errors++; $display("FAIL udf_clear: got %b want 0", udf_err); end
   endtask

   task automatic test_cmd_err;
      apply_reset();
      do_cmd(1, 0, 0, 8'h01, 0);
      do_cmd(1, 0, 0, 8'h02, 0);
      do_cmd(1, 0, 0, 8'h03, 0);
      do_cmd(1, 1, 0, 8'h99, 0);
      checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL cmd_flag: got %b want 1", cmd_err); end
      checks++; if (count !== 5'd3) begin errors++; $display("FAIL cmd_count: got %0d want 3", count); end
      checks++; if (dout_vld !== 1'b0) begin errors++; $display("FAIL cmd_vld: got %b want 0", dout_vld); end
      checks++; if ({ovf_err, udf_err} !== 2'b00) begin errors++; $display("FAIL cmd_other_flags: got %b want 00", {ovf_err, udf_err}); end
      do_cmd(0, 0, 1, 8'h00, 0);
      checks++; if (dout !== 8'h03) begin errors++; $display("FAIL cmd_top: got %h want 03", dout); end
      checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL cmd_sticky: got %b want 1", cmd_err); end
   endtask

   // Continues from test_cmd_err state (count=3, cmd_err set).
   task automatic test_reset_mid;
      do_cmd(1, 0, 0, 8'h33, 0);
      pop = 1;
      #3 rst = 1;
      #1;
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL rmid_count: got %0d want 0", count); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rmid_empty: got %b want 1", empty); end
      checks++; if (dout !== 8'h00) begin errors++; $display("FAIL rmid_dout: got %h want 00", dout); end
      checks++; if (dout_vld !== 1'b0) begin errors++; $display("FAIL rmid_vld: got %b want 0", dout_vld); end
      checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL rmid_cmd_err: got %b want 0", cmd_err); end
      pop = 0;
      @(posedge clk); #3;
      rst = 0;
      @(posedge clk); #1;
      do_cmd(1, 0, 0, 8'h44, 0);
      do_cmd(0, 1, 0, 8'h00, 0);
      checks++; if (dout !== 8'h44) begin errors++; $display("FAIL rmid_pop_dout: got %h want 44", dout); end
      checks++; if (dout_vld !== 1'b1) begin errors++; $display("FAIL rmid_pop_vld: got %b want 1", dout_vld); end
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL rmid_pop_count: got %0d want 0", count); end
   endtask

   initial begin
      rst = 1; push = 0; pop = 0; tos = 0; din = '0; clr_err = 0;
      test_reset();
      test_push_pop();
      test_tos();
      test_overflow();
      test_underflow();
      test_cmd_err();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Hardware operand stack for the multi-cycle stack processor; the responder end of the controller's push/pop/tos command interface.
- Executes one command per cycle and returns a registered top-of-stack value, which the datapath latches into A/B one cycle later.
- Detects full, empty, overflow, underflow and illegal multi-command cycles, and keeps sticky error flags for debug and verification.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of entries; must be a power of two and at least 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter; derived, never overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- push  in  1  write din onto the stack this cycle.
- pop  in  1  remove the top entry and return it on dout.
- tos  in  1  return the top entry on dout without removing it.
- din  in  WIDTH  push data, driven by the datapath stack mux.
- clr_err  in  1  synchronous clear of all sticky error flags.
- dout  out  WIDTH  registered top-of-stack data.
- dout_vld  out  1  one-cycle pulse: dout was updated by a legal pop or tos.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- count  out  CNT_W  current occupancy.
- ovf_err  out  1  sticky: push attempted while full.
- udf_err  out  1  sticky: pop or tos attempted while empty.
- cmd_err  out  1  sticky: more than one of push/pop/tos asserted in the same cycle.

Behaviour:
- Reset, asynchronous: sp=0, count=0, dout=0, dout_vld=0, all error flags 0, empty=1, full=0.
- Memory contents are not reset and are undefined until written.
- Storage: entries mem[0..DEPTH-1]; sp points to the next free slot; top entry is mem[sp-1]; count == sp.
- Command decode: at most one of push/pop/tos may be asserted per cycle.
  - If two or more are asserted: no memory write, no sp change, dout holds, dout_vld=0, cmd_err set.
  - Over/underflow checks are skipped on that cycle.
- Legal push, not full: mem[sp] <= din; sp <= sp+1 at the clock edge. dout is unchanged and dout_vld=0.
- Legal pop, not empty: dout <= mem[sp-1]; sp <= sp-1; dout_vld=1 in the next cycle.
- Legal tos, not empty: dout <= mem[sp-1]; sp unchanged; dout_vld=1 in the next cycle.
- Latency: a command sampled at edge N makes dout valid after edge N. dout then holds until the next legal pop or tos, so the controller's pop-then-en_A two-state sequence always captures the correct value.
- Push then pop on consecutive cycles: the pop returns the just-pushed value; the write completes at the push edge, so no bypass is needed.
- Overflow: push while full is ignored (no write, sp held) and sets ovf_err.
- Underflow: pop or tos while empty is ignored (dout held, dout_vld=0) and sets udf_err.
- full and empty are combinational from count and update in the same cycle as count.
- No wrap-around: sp saturates at both 0 and DEPTH because illegal operations are suppressed.
- Sticky flags:
  - A flag stays set until clr_err or rst.
  - If clr_err and a new error occur in the same cycle, the flag ends set (error wins).
  - Flags never block later legal commands.
- Reset mid-operation: rst asserted during any command aborts it immediately. The stack is logically empty after release, regardless of memory contents.

Decomposition:
- Shared package stack_pkg:
  - default STACK_WIDTH and STACK_DEPTH constants;
  - a cmd_t enumeration (NONE, PUSH, POP, TOS, ILLEGAL) produced by a one-hot check of push/pop/tos.
- One sub-module, stack_ram: DEPTH x WIDTH register file with synchronous write and asynchronous read, addressed by sp (write) and sp-1 (read).
- All pointer, counter, flag and dout logic stays in stack_unit.

Test Plan:
- Reset, then push 8'h05 and push 8'h0A, then pop -> dout=8'h0A with a dout_vld pulse; count=1.
- From that state, tos twice -> dout=8'h05 both times; count stays 1; then pop -> count=0, empty=1.
- Push 16 values 0..15 -> full=1, count=16. One more push of 8'hFF -> ovf_err=1, count=16. Then pop -> dout=8'h0F.
- On an empty stack, pop then tos -> udf_err=1, dout unchanged, dout_vld never pulses. Pulse clr_err -> udf_err=0.
- Assert push=1 and pop=1 together with count=3 -> cmd_err=1, count=3, memory top unchanged.
- Push 8'h33, then assert rst asynchronously mid-cycle during a pop -> all outputs at reset values immediately. Push 8'h44 then pop -> dout=8'h44.
